// File: rtl/piso_seq_ctrl.sv
// Sequencer for a WIDTH-bit PISO: one-entry holding register on a valid/ready input,
// load/shift strobes, per-bit valid/first/last flags, programmable bit period and inter-word gap.
module piso_seq_ctrl #(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 1,
   parameter int GAP_CYCLES   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             piso_load,
   output logic             piso_shift,
   output logic [WIDTH-1:0] piso_data,
   output logic             bit_valid,
   output logic             bit_first,
   output logic             bit_last,
   output logic             busy,
   output logic [15:0]      words_sent
);

   localparam int BW = $clog2(WIDTH);
   localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t           state_q, state_d;
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;
   logic [WIDTH-1:0] piso_data_q, piso_data_d;
   logic             in_ready_q, in_ready_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [15:0]      words_sent_q, words_sent_d;
   logic             drain;
   logic             accept;

   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d      = state_q;
      hold_full_d  = hold_full_q;
      hold_data_d  = hold_data_q;
      piso_data_d  = piso_data_q;
      bit_cnt_d    = bit_cnt_q;
      div_cnt_d    = div_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      words_sent_d = words_sent_q;
      piso_load    = 1'b0;
      piso_shift   = 1'b0;
      bit_valid    = 1'b0;
      bit_first    = 1'b0;
      bit_last     = 1'b0;
      drain        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (hold_full_q && enable) state_d = LOAD;
         end
         LOAD: begin
            piso_load = 1'b1;
            drain     = 1'b1;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            bit_valid = 1'b1;
            bit_first = (bit_cnt_q == '0);
            bit_last  = (bit_cnt_q == BIT_LAST);
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
                  words_sent_d = words_sent_q + 16'd1;
                  bit_cnt_d    = '0;
                  // Zero-bubble reload replaces the final shift with a load and stays in SHIFT
                  if (GAP_CYCLES == 0 && hold_full_q && enable) begin
                     piso_load = 1'b1;
                     drain     = 1'b1;
                  end else if (GAP_CYCLES > 0) begin
                     gap_cnt_d = '0;
                     state_d   = GAP;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  piso_shift = 1'b1;
                  bit_cnt_d  = bit_cnt_q + BW'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DW'(1);
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = (hold_full_q && enable) ? LOAD : IDLE;
            else gap_cnt_d = gap_cnt_q + GW'(1);
         end
         default: state_d = IDLE;
      endcase

      if (drain) begin
         hold_full_d = 1'b0;
         piso_data_d = hold_data_q;
      end else if (accept) begin
         hold_full_d = 1'b1;
         hold_data_d = in_data;
      end
      in_ready_d = ~hold_full_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hold_full_q  <= 1'b0;
         hold_data_q  <= '0;
         piso_data_q  <= '0;
         in_ready_q   <= 1'b0;
         bit_cnt_q    <= '0;
         div_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         words_sent_q <= '0;
      end else begin
         state_q      <= state_d;
         hold_full_q  <= hold_full_d;
         hold_data_q  <= hold_data_d;
         piso_data_q  <= piso_data_d;
         in_ready_q   <= in_ready_d;
         bit_cnt_q    <= bit_cnt_d;
         div_cnt_q    <= div_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         words_sent_q <= words_sent_d;
      end
   end

   // The word being loaded is shown during its load clock so the PISO captures it at that edge
   assign piso_data  = piso_load ? hold_data_q : piso_data_q;
   assign in_ready   = in_ready_q;
   assign busy       = (state_q != IDLE) | hold_full_q;
   assign words_sent = words_sent_q;

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Scoreboard bench for piso_seq_ctrl: two configurations (continuous stream, and slow bits with
// an inter-word gap), each driving a bench-side PISO and checking its serial stream.
module tb_piso_seq_ctrl;

   localparam int W = 4;

   typedef struct {
      logic s;
      logic f;
      logic l;
      logic st;
      logic e;
   } exp_t;

   logic clk = 1'b0;
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int CPB = (g == 0) ? 1 : 3;
      localparam int GAP = (g == 0) ? 0 : 2;

      logic          rst_n;
      logic          enable;
      logic          in_valid;
      logic          in_ready;
      logic [W-1:0]  in_data;
      logic          piso_load;
      logic          piso_shift;
      logic [W-1:0]  piso_data;
      logic          bit_valid;
      logic          bit_first;
      logic          bit_last;
      logic          busy;
      logic [15:0]   words_sent;

      piso_seq_ctrl #(
         .WIDTH(W),
         .CLKS_PER_BIT(CPB),
         .GAP_CYCLES(GAP)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .enable(enable),
         .in_valid(in_valid),
         .in_ready(in_ready),
         .in_data(in_data),
         .piso_load(piso_load),
         .piso_shift(piso_shift),
         .piso_data(piso_data),
         .bit_valid(bit_valid),
         .bit_first(bit_first),
         .bit_last(bit_last),
         .busy(busy),
         .words_sent(words_sent)
      );

      // External PISO, MSB first, shift_in = 0
      logic [W-1:0] sr;
      logic         serial_out;
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n)          sr <= '0;
         else if (piso_load)  sr <= piso_data;
         else if (piso_shift) sr <= {sr[W-2:0], 1'b0};
      end
      assign serial_out = sr[W-1];

      exp_t q[$];
      int   exp_words  = 0;
      int   run_invalid = 0;
      int   last_gap   = -1;

      // Each word yields W bits, MSB first, each held CPB clocks
      task automatic push_word(input logic [W-1:0] w);
         for (int b = 0; b < W; b++) begin
            for (int k = 0; k < CPB; k++) begin
               exp_t e;
               e.s  = w[W-1-b];
               e.f  = (b == 0);
               e.l  = (b == W - 1);
               e.st = (b == 0) && (k == 0);
               e.e  = (b == W - 1) && (k == CPB - 1);
               q.push_back(e);
            end
         end
      endtask

      always @(negedge clk) begin
         exp_t e;
         if (rst_n) begin
            chk($sformatf("words_sent[%0d]", g), words_sent, exp_words % 65536);
            if (piso_load || piso_shift)
               chk($sformatf("strobe_excl[%0d]", g), piso_load & piso_shift, 0);
            if (bit_valid) begin
               if (q.size() == 0) begin
                  chk($sformatf("unexpected_bit[%0d]", g), 1, 0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("serial[%0d]", g), serial_out, e.s);
                  chk($sformatf("first[%0d]", g), bit_first, e.f);
                  chk($sformatf("last[%0d]", g), bit_last, e.l);
                  if (e.st) last_gap = run_invalid;
                  if (e.e) exp_words++;
               end
               run_invalid = 0;
            end else begin
               run_invalid++;
            end
         end
      end

      task automatic send(input logic [W-1:0] w, input bit rnd_en);
         int n;
         n        = 0;
         in_valid = 1'b1;
         in_data  = w;
         while (!in_ready && n < 300) begin
            @(negedge clk);
            if (rnd_en) enable = ($urandom_range(0, 3) != 0);
            n++;
         end
         if (!in_ready) begin
            chk($sformatf("accept_timeout[%0d]", g), 0, 1);
         end else begin
            push_word(w);
         end
         @(negedge clk);
         in_valid = 1'b0;
      endtask

      task automatic wait_idle();
         int n;
         n = 0;
         while ((busy || q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("idle_reached[%0d]", g), (n < 500) ? 1 : 0, 1);
      endtask

      task automatic wait_bit();
         int n;
         n = 0;
         while (!bit_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("bit_seen[%0d]", g), bit_valid, 1);
      endtask

      initial begin : stim
         rst_n    = 1'b0;
         enable   = 1'b0;
         in_valid = 1'b0;
         in_data  = '0;
         #23;
         chk($sformatf("rst_ready[%0d]", g), in_ready, 0);
         chk($sformatf("rst_valid[%0d]", g), bit_valid, 0);
         chk($sformatf("rst_load[%0d]", g), piso_load, 0);
         chk($sformatf("rst_data[%0d]", g), piso_data, 0);
         chk($sformatf("rst_busy[%0d]", g), busy, 0);
         chk($sformatf("rst_words[%0d]", g), words_sent, 0);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk($sformatf("ready_after_rst[%0d]", g), in_ready, 1);
         enable = 1'b1;

         // Idle-start latency: accept edge, one LOAD clock, then bits
         in_valid = 1'b1;
         in_data  = 4'hB;
         push_word(4'hB);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("lat_no_load_yet[%0d]", g), piso_load, 0);
         chk($sformatf("lat_ready_low[%0d]", g), in_ready, 0);
         @(negedge clk);
         chk($sformatf("lat_load[%0d]", g), piso_load, 1);
         chk($sformatf("lat_load_data[%0d]", g), piso_data, 4'hB);
         chk($sformatf("lat_no_valid[%0d]", g), bit_valid, 0);
         @(negedge clk);
         chk($sformatf("lat_first_bit[%0d]", g), bit_valid & bit_first, 1);
         wait_idle();
         chk($sformatf("idle_busy[%0d]", g), busy, 0);
         chk($sformatf("idle_ready[%0d]", g), in_ready, 1);

         // Back-to-back: contiguous with no gap, or GAP idle clocks plus the LOAD clock
         send(4'hB, 1'b0);
         send(4'h5, 1'b0);
         wait_idle();
         chk($sformatf("stream_gap[%0d]", g), last_gap, (GAP == 0) ? 0 : GAP + 1);

         // enable dropped mid-word with a second word held
         send(4'h3, 1'b0);
         send(4'hC, 1'b0);
         enable = 1'b0;
         repeat (30) @(negedge clk);
         chk($sformatf("hold_ready_low[%0d]", g), in_ready, 0);
         chk($sformatf("hold_busy[%0d]", g), busy, 1);
         chk($sformatf("hold_no_valid[%0d]", g), bit_valid, 0);
         chk($sformatf("hold_remaining[%0d]", g), q.size(), W * CPB);
         enable = 1'b1;
         @(negedge clk);
         chk($sformatf("reenable_load[%0d]", g), piso_load, 1);
         wait_idle();

         // Asynchronous reset during bit 2
         send(4'h9, 1'b0);
         wait_bit();
         repeat (2 * CPB) @(negedge clk);
         #2 rst_n = 1'b0;
         #1;
         chk($sformatf("arst_valid[%0d]", g), bit_valid, 0);
         chk($sformatf("arst_shift[%0d]", g), piso_shift, 0);
         chk($sformatf("arst_load[%0d]", g), piso_load, 0);
         chk($sformatf("arst_ready[%0d]", g), in_ready, 0);
         chk($sformatf("arst_busy[%0d]", g), busy, 0);
         chk($sformatf("arst_words[%0d]", g), words_sent, 0);
         chk($sformatf("arst_data[%0d]", g), piso_data, 0);
         q.delete();
         exp_words = 0;
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk($sformatf("arst_ready_back[%0d]", g), in_ready, 1);
         send(4'h6, 1'b0);
         wait_idle();

         // Randomised traffic with random idle spacing and enable drops
         repeat (40) begin
            repeat ($urandom_range(0, 5)) begin
               @(negedge clk);
               enable = ($urandom_range(0, 3) != 0);
            end
            send(W'($urandom), 1'b1);
         end
         enable = 1'b1;
         wait_idle();
         chk($sformatf("final_queue_empty[%0d]", g), q.size(), 0);
         done_cnt++;
      end
   end

   initial begin
      fork
         wait (done_cnt == 2);
         #2_000_000;
      join_any
      if (done_cnt != 2) begin
         errors++;
         $display("FAIL watchdog actual=%0d expected=2 finished instances", done_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
